// File: rtl/instr_issue.sv
// Fetch/issue front end: sequences the PC, fetches words over a req/valid
// handshake and presents opcode/cmp_flag/operand to decode under valid/ready.
module instr_issue #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [3:0]          opcode,
    output logic [1:0]          cmp_flag,
    output logic [INSTR_W-7:0]  operand,
    output logic [ADDR_W-1:0]   issue_pc,
    input  logic                branch_resolve,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                busy,
    output logic                done,
    output logic [15:0]         issue_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        HOLD,
        BR_WAIT,
        DONE
    } state_t;

    localparam logic [3:0] OP_BRANCH = 4'b1110;
    localparam logic [3:0] OP_NOP    = 4'b1111;
    localparam int         OPND_W    = INSTR_W - 6;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n, pc_inc, issue_pc_n;
    logic [INSTR_W-1:0]  instr, instr_n;
    logic [15:0]         count_n;
    logic                req_n, valid_n, busy_n, done_n;
    logic [3:0]          opcode_n;
    logic [1:0]          cmp_n;
    logic [OPND_W-1:0]   operand_n;
    logic                at_end;

    assign imem_addr = pc;
    assign pc_inc    = pc + ADDR_W'(1);
    assign at_end    = (pc == end_addr);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        issue_pc_n = issue_pc;
        count_n    = issue_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    pc_n    = start_addr;
                    count_n = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = WAIT_MEM;
            WAIT_MEM: begin
                if (imem_valid) begin
                    instr_n    = imem_data;
                    issue_pc_n = pc;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (issue_ready) begin
                    if (issue_count != '1) count_n = issue_count + 16'd1;
                    if (instr[INSTR_W-1 -: 4] == OP_BRANCH) begin
                        state_n = BR_WAIT;
                    end else if (at_end) begin
                        state_n = DONE;
                    end else begin
                        pc_n    = pc_inc;
                        state_n = FETCH;
                    end
                end
            end
            BR_WAIT: begin
                if (branch_resolve) begin
                    if (branch_taken) begin
                        pc_n    = branch_target;
                        state_n = FETCH;
                    end else if (at_end) begin
                        state_n = DONE;
                    end else begin
                        pc_n    = pc_inc;
                        state_n = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so they can be registered
        // and still line up with the state they describe.
        req_n     = (state_n == FETCH);
        valid_n   = (state_n == HOLD);
        busy_n    = (state_n != IDLE) && (state_n != DONE);
        done_n    = (state_n == DONE);
        opcode_n  = valid_n ? instr_n[INSTR_W-1 -: 4] : OP_NOP;
        cmp_n     = valid_n ? instr_n[INSTR_W-5 -: 2] : 2'b00;
        operand_n = valid_n ? instr_n[OPND_W-1:0]     : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            issue_pc    <= '0;
            issue_count <= '0;
            imem_req    <= 1'b0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            opcode      <= OP_NOP;
            cmp_flag    <= '0;
            operand     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            issue_pc    <= issue_pc_n;
            issue_count <= count_n;
            imem_req    <= req_n;
            issue_valid <= valid_n;
            busy        <= busy_n;
            done        <= done_n;
            opcode      <= opcode_n;
            cmp_flag    <= cmp_n;
            operand     <= operand_n;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Randomized bench for instr_issue: a transaction-level model predicts fetch
// addresses, issued words, counts and status, checked every cycle.
module tb_instr_issue;

    localparam int AW = 4;
    localparam int IW = 24;
    localparam int OW = IW - 6;

    logic           clk, rst_n, start;
    logic [AW-1:0]  start_addr, end_addr;
    logic           imem_req;
    logic [AW-1:0]  imem_addr;
    logic           imem_valid;
    logic [IW-1:0]  imem_data;
    logic           issue_valid, issue_ready;
    logic [3:0]     opcode;
    logic [1:0]     cmp_flag;
    logic [OW-1:0]  operand;
    logic [AW-1:0]  issue_pc;
    logic           branch_resolve, branch_taken;
    logic [AW-1:0]  branch_target;
    logic           busy, done;
    logic [15:0]    issue_count;

    instr_issue #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .cmp_flag(cmp_flag), .operand(operand),
        .issue_pc(issue_pc), .branch_resolve(branch_resolve),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .busy(busy), .done(done), .issue_count(issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int tests, fails, cyc, start_cyc;
    logic [IW-1:0] mem [16];

    // Model of what the outputs must show in the coming cycle.
    bit            exp_req, exp_valid, exp_busy, exp_done;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_word;
    int            m_count;
    bit            br_pending;
    int            br_wait, mem_cnt;
    logic [AW-1:0] mem_addr;

    int            ready_pct, min_lat, max_lat, br_delay, stall_left, taken_mode, taken_budget;
    logic [AW-1:0] br_target_knob, req_sa;
    bit            spur_en, start_req, rst_req, late_data;
    int            fetch_log[$];
    int            valid_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_seq(input string nm, input int q[$], input int n, input int e[10]);
        chk({nm, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++)
            chk($sformatf("%s_%0d", nm, i), 32'(q[i]), 32'(e[i]));
    endtask

    function automatic logic [IW-1:0] rand_word(input bit branch);
        logic [IW-1:0] w;
        w = IW'($urandom);
        if (branch) w[IW-1 -: 4] = 4'hE;
        else if (w[IW-1 -: 4] == 4'hE) w[IW-1 -: 4] = 4'h3;
        return w;
    endfunction

    task automatic tick();
        bit req_now, hold_now, br_now, busy_now, rdy, tk;
        @(negedge clk);
        cyc++;
        req_now  = exp_req;
        hold_now = exp_valid;
        br_now   = br_pending;
        busy_now = exp_busy;

        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("issue_valid", 32'(issue_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("opcode", 32'(opcode), 32'(m_word[IW-1 -: 4]));
            chk("cmp_flag", 32'(cmp_flag), 32'(m_word[IW-5 -: 2]));
            chk("operand", 32'(operand), 32'(m_word[OW-1:0]));
            chk("issue_pc", 32'(issue_pc), 32'(m_addr));
        end else begin
            chk("idle_opcode", 32'(opcode), 32'h0000000F);
            chk("idle_cmp_flag", 32'(cmp_flag), 32'h0);
            chk("idle_operand", 32'(operand), 32'h0);
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("issue_count", 32'(issue_count), 32'(m_count));
        if (imem_req) fetch_log.push_back(int'(imem_addr));
        if (issue_valid) valid_log.push_back(cyc - start_cyc);

        rst_n          = 1'b1;
        start          = 1'b0;
        branch_resolve = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = AW'($urandom);
        imem_valid     = 1'b0;
        imem_data      = IW'($urandom);
        issue_ready    = 1'($urandom);
        exp_req        = 1'b0;

        // Reset together with start: reset must win and in-flight data is dropped.
        if (rst_req) begin
            rst_req    = 1'b0;
            rst_n      = 1'b0;
            start      = 1'b1;
            start_addr = AW'($urandom);
            exp_valid  = 1'b0;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            m_count    = 0;
            m_addr     = '0;
            br_pending = 1'b0;
            stall_left = 0;
            if (mem_cnt > 0) late_data = 1'b1;
            mem_cnt    = 0;
            return;
        end
        if (late_data) begin
            late_data  = 1'b0;
            imem_valid = 1'b1;
        end

        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_data  = mem[mem_addr];
                m_word     = mem[mem_addr];
                exp_valid  = 1'b1;
            end
        end
        if (req_now) begin
            mem_cnt  = int'($urandom_range(max_lat, min_lat)) + 1;
            mem_addr = m_addr;
        end
        if (spur_en && !imem_valid && (req_now || mem_cnt == 0) && $urandom_range(3, 0) == 0)
            imem_valid = 1'b1;

        if (hold_now) begin
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = int'($urandom_range(99, 0)) < ready_pct;
            end
            issue_ready = rdy;
            if (rdy) begin
                exp_valid = 1'b0;
                if (m_count < 65535) m_count++;
                if (m_word[IW-1 -: 4] == 4'hE) begin
                    br_pending = 1'b1;
                    br_wait    = (br_delay >= 0) ? br_delay : int'($urandom_range(5, 0));
                end else if (m_addr == end_addr) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                end else begin
                    m_addr  = AW'(m_addr + 1);
                    exp_req = 1'b1;
                end
            end
        end

        if (br_now) begin
            if (br_wait > 0) begin
                br_wait--;
            end else begin
                tk = (taken_mode == 1) ||
                     (taken_mode == 2 && taken_budget > 0 && $urandom_range(1, 0) == 1);
                if (tk && taken_mode == 2) taken_budget--;
                branch_resolve = 1'b1;
                branch_taken   = tk;
                br_pending     = 1'b0;
                if (taken_mode == 1) branch_target = br_target_knob;
                if (tk) begin
                    m_addr  = branch_target;
                    exp_req = 1'b1;
                end else if (m_addr == end_addr) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                end else begin
                    m_addr  = AW'(m_addr + 1);
                    exp_req = 1'b1;
                end
            end
        end else if (spur_en && $urandom_range(4, 0) == 0) begin
            branch_resolve = 1'b1;
            branch_taken   = 1'b1;
        end

        if (start_req && !busy_now) begin
            start_req  = 1'b0;
            start      = 1'b1;
            start_addr = req_sa;
            m_addr     = req_sa;
            m_count    = 0;
            exp_req    = 1'b1;
            exp_busy   = 1'b1;
            exp_done   = 1'b0;
            start_cyc  = cyc;
            fetch_log.delete();
            valid_log.delete();
        end else if (spur_en && busy_now && $urandom_range(9, 0) == 0) begin
            start      = 1'b1;
            start_addr = AW'($urandom);
        end
    endtask

    task automatic run_prog(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        int n;
        end_addr  = ea;
        req_sa    = sa;
        start_req = 1'b1;
        tick();
        n = 0;
        while (!exp_done && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("program_bound", 32'(done), 32'h1);
        tick();
    endtask

    task automatic fill_mem(input int branch_pct);
        for (int i = 0; i < 16; i++)
            mem[i] = rand_word(int'($urandom_range(99, 0)) < branch_pct);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; start_cyc = 0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
        imem_valid = 1'b0; imem_data = '0; issue_ready = 1'b0;
        branch_resolve = 1'b0; branch_taken = 1'b0; branch_target = '0;
        exp_req = 0; exp_valid = 0; exp_busy = 0; exp_done = 0;
        m_addr = '0; m_word = '0; m_count = 0; br_pending = 0; br_wait = 0;
        mem_cnt = 0; mem_addr = '0;
        ready_pct = 100; min_lat = 0; max_lat = 0; br_delay = -1; stall_left = 0;
        taken_mode = 0; taken_budget = 0; br_target_knob = '0; req_sa = '0;
        spur_en = 0; start_req = 0; rst_req = 0; late_data = 0;
        fill_mem(0);
        repeat (3) @(posedge clk);

        tick();
        chk("reset_issue_pc", 32'(issue_pc), 32'h0);
        chk("reset_imem_addr", 32'(imem_addr), 32'h0);
        chk("reset_opcode", 32'(opcode), 32'hF);

        // Linear program, 1-cycle memory, always ready.
        run_prog(4'd0, 4'd3);
        chk_seq("lin_valid", valid_log, 4, '{3, 6, 9, 12, 0, 0, 0, 0, 0, 0});
        chk_seq("lin_fetch", fetch_log, 4, '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0});
        chk("lin_done", 32'(done), 32'h1);
        chk("lin_count", 32'(issue_count), 32'd4);

        // Backpressure: five stalled cycles on the first word.
        stall_left = 5;
        run_prog(4'd0, 4'd3);
        chk_seq("bp_valid", valid_log, 9, '{3, 4, 5, 6, 7, 8, 11, 14, 17, 0});
        chk("bp_count", 32'(issue_count), 32'd4);

        // Taken branch at PC 2 to 7.
        fill_mem(0);
        mem[2] = rand_word(1);
        mem[2][IW-5 -: 2] = 2'b01;
        taken_mode = 1; br_target_knob = 4'd7; br_delay = 4;
        run_prog(4'd0, 4'd9);
        chk_seq("br_fetch", fetch_log, 6, '{0, 1, 2, 7, 8, 9, 0, 0, 0, 0});
        chk("br_count", 32'(issue_count), 32'd6);

        // Untaken branch sitting at end_addr, with spurious resolves/valids/starts.
        fill_mem(0);
        mem[5] = rand_word(1);
        taken_mode = 0; br_delay = -1; spur_en = 1;
        ready_pct = 50; max_lat = 2;
        run_prog(4'd3, 4'd5);
        chk_seq("nt_fetch", fetch_log, 3, '{3, 4, 5, 0, 0, 0, 0, 0, 0, 0});
        chk("nt_done", 32'(done), 32'h1);

        // PC wrap with random latency.
        fill_mem(0);
        ready_pct = 70; max_lat = 6;
        run_prog(4'd15, 4'd1);
        chk_seq("wrap_fetch", fetch_log, 3, '{15, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        chk("wrap_count", 32'(issue_count), 32'd3);

        // Random programs with a bounded number of taken branches.
        taken_mode = 2; max_lat = 3; ready_pct = 60;
        for (int r = 0; r < 8; r++) begin
            fill_mem(20);
            taken_budget = 3;
            run_prog(AW'($urandom), AW'($urandom));
        end

        // Reset while waiting on memory; late data must be dropped.
        fill_mem(0);
        taken_mode = 0; spur_en = 0; min_lat = 4; max_lat = 4;
        end_addr = 4'd9; req_sa = 4'd0; start_req = 1'b1;
        tick();
        tick();
        tick();
        rst_req = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(issue_valid), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'hF);
        chk("rst_issue_pc", 32'(issue_pc), 32'h0);
        chk("rst_count", 32'(issue_count), 32'h0);
        repeat (3) tick();

        min_lat = 0; max_lat = 2; ready_pct = 80;
        run_prog(4'd2, 4'd4);
        chk("post_rst_count", 32'(issue_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Fetch/issue front end that generates the opcode/CMP_Flag stream consumed by the control decoder.
- Sequences a program counter and fetches instruction words from instruction memory over a req/valid handshake.
- Splits each word into opcode, compare flag and operand fields, and presents them to the decode stage under a valid/ready handshake.
- Stalls on branches (opcode 1110) until execute resolves them, then redirects the PC.

Parameters:
- ADDR_W, 10, width of PC and instruction-memory address.
- INSTR_W, 24, instruction word width; must be ≥ 8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at start_addr (honoured in IDLE and DONE only).
- start_addr  in  ADDR_W  first PC.
- end_addr  in  ADDR_W  last PC of program; sampled every cycle.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  ADDR_W  fetch address, equals pc.
- imem_valid  in  1  instruction data valid.
- imem_data  in  INSTR_W  instruction word.
- issue_valid  out  1  decode fields valid.
- issue_ready  in  1  decode stage accepts.
- opcode  out  4  imem_data[INSTR_W-1:INSTR_W-4] of held word.
- cmp_flag  out  2  imem_data[INSTR_W-5:INSTR_W-6] of held word.
- operand  out  INSTR_W-6  remaining low bits of held word.
- issue_pc  out  ADDR_W  PC of held instruction.
- branch_resolve  in  1  execute stage: branch outcome valid.
- branch_taken  in  1  outcome; qualified by branch_resolve.
- branch_target  in  ADDR_W  target PC when taken.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.
- issue_count  out  16  instructions accepted since last start; saturates at 16'hFFFF.

Behaviour:
- States: IDLE, FETCH, WAIT_MEM, HOLD, BR_WAIT, DONE. All outputs are registered.
- Reset (rst_n=0 at an edge, any state):
  - State goes to IDLE.
  - pc, instr register, issue_count and issue_pc all go to 0.
  - imem_req, issue_valid, busy and done go to 0.
  - An in-flight imem_valid arriving after reset is ignored.
- Decoder-facing idle value: whenever issue_valid=0, opcode is forced to 4'b1111 (NOP), and cmp_flag and operand are forced to 0. The decoder must never see a stale opcode.
- IDLE: on start, pc<=start_addr, issue_count<=0, go to FETCH.
- FETCH: imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT_MEM.
- WAIT_MEM:
  - Memory latency is unbounded. On imem_valid, capture imem_data and pc (into issue_pc), then go to HOLD.
  - imem_valid in any other state is ignored.
- HOLD:
  - issue_valid=1; fields stable until the handshake completes.
  - On issue_ready (handshake):
    - issue_count increments (saturating).
    - If opcode==1110, go to BR_WAIT.
    - Else if pc==end_addr, go to DONE.
    - Else pc<=pc+1 and go to FETCH.
- BR_WAIT:
  - issue_valid=0; no fetch.
  - On branch_resolve: if branch_taken, pc<=branch_target and go to FETCH (end_addr check not applied).
  - If not taken: if pc==end_addr, go to DONE; else pc<=pc+1 and go to FETCH.
  - branch_resolve outside BR_WAIT is ignored, including in the handshake cycle itself; the earliest accepted resolve is the cycle after the handshake.
- DONE:
  - done=1 and busy=0 are held.
  - start restarts exactly as from IDLE; done drops the cycle after start.
- start in the busy states is ignored.
- PC arithmetic: pc+1 is modulo 2^ADDR_W (pc at max wraps to 0).
- Throughput: at most one issue per 3 cycles with zero-latency memory.
  - Fastest sequence: FETCH at cycle t, imem_valid at t+1, issue_valid at t+2.
- Simultaneous rst_n=0 and start: reset wins.

Test Plan:
- Linear program: start_addr=0, end_addr=3, memory returns data 1 cycle after req, issue_ready=1 -> opcodes issued for PCs 0,1,2,3 in order; issue_valid is high at cycles 3,6,9,12 after start; done=1 afterwards; issue_count=4.
- Backpressure: hold issue_ready=0 for 5 cycles in HOLD -> opcode, cmp_flag, operand and issue_pc stay constant; no imem_req; count increments exactly once on release.
- Branch taken: word at PC 2 has opcode 1110 with cmp_flag=01; resolve after 4 cycles with taken=1, target=7 -> no imem_req during the wait; next imem_addr=7; opcode outputs 1111 during BR_WAIT.
- Branch not taken at end_addr: branch at PC=end_addr=5, resolve taken=0 -> DONE with no further fetch. Also pulse branch_resolve in HOLD -> ignored.
- Wrap and latency: ADDR_W=4, start_addr=15, end_addr=1, memory latency 0–6 random cycles -> fetch sequence 15,0,1; done=1; a spurious imem_valid in FETCH/HOLD is ignored.
- Reset mid-operation: assert rst_n=0 during WAIT_MEM, then deliver imem_valid the next cycle -> IDLE; all outputs at reset values; opcode=1111; the late data does not appear on the decode outputs after reset release.
